aes_host_ctrl: RTL and testbench
================================

# aes_host_ctrl

Request-side controller that drives the AES core wrapper: `mode`, `ld`, `kld`, `key`, `text_in`, with `text_out`/`done` returned. It takes 128-bit encrypt/decrypt jobs over a valid/ready request port and sequences the core's load and key-expansion strobes. It captures the core result and returns it over a valid/ready response port, with a timeout error path. For decryption it caches the last expanded key, so a repeated decrypt key skips key expansion.

## Interface
Parameters:
- `KEY_EXP_CYCLES`, default 12: cycles waited after `aes_kld` before `aes_ld` (inverse-cipher key expansion); legal 1..255
- `TIMEOUT`, default 64: BUSY cycles without `aes_done` before error response; legal 1..65535

Ports:
- `clk`  in  1: single clock, all logic on rising edge
- `rst`  in  1: asynchronous, active-low reset
- `req_valid`  in  1: request present
- `req_ready`  out  1: controller accepts request
- `req_mode`  in  1: 0 = encrypt, 1 = decrypt
- `req_key`  in  128: cipher key
- `req_data`  in  128: plaintext (encrypt) or ciphertext (decrypt)
- `rsp_valid`  out  1: response present
- `rsp_ready`  in  1: consumer accepts response
- `rsp_data`  out  128: result block; 0 on error
- `rsp_mode`  out  1: mode of the completed job
- `rsp_err`  out  1: 1 = timeout, no result
- `aes_mode`  out  1: to core `mode`
- `aes_ld`  out  1: to core `ld`, single-cycle pulse
- `aes_kld`  out  1: to core `kld`, single-cycle pulse, decrypt only
- `aes_key`  out  128: to core `key`
- `aes_text_in`  out  128: to core `text_in`
- `aes_text_out`  in  128: from core `text_out`
- `aes_done`  in  1: from core `done`

## Operation
- States: IDLE, KLD, KWAIT, LOAD, BUSY, RESP.
- `req_ready` = (state == IDLE). On accept (`req_valid && req_ready`), the controller registers mode, key and data into `aes_mode`, `aes_key` and `aes_text_in`. These stay stable until the next accept.
- From IDLE:
  - Encrypt: go to LOAD.
  - Decrypt with cache hit (`kvalid && req_key == kcache`): go to LOAD.
  - Decrypt with cache miss: go to KLD.
- KLD: `aes_kld`=1 for one cycle. Load `kcache` = key and set `kvalid`=1. Go to KWAIT with `wcnt`=KEY_EXP_CYCLES.
- KWAIT: decrement `wcnt`. When it reaches 1, go to LOAD on the next edge (exactly KEY_EXP_CYCLES cycles in KWAIT).
- LOAD: `aes_ld`=1 for one cycle. Clear the timeout counter. Go to BUSY.
- BUSY: sample `aes_done`.
  - If set: capture `aes_text_out` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - Else increment the counter. When the counter reaches TIMEOUT: `rsp_data`=0, `rsp_err`=1, `kvalid`=0, go to RESP.
  - If `aes_done` and timeout coincide in the same cycle, `aes_done` wins.
- RESP: `rsp_valid`=1. Data, mode and err are held until `rsp_ready`; then go to IDLE.
- `aes_done` outside BUSY is ignored and changes no state.
- Encrypt jobs never read or modify the key cache.
- Counter widths: `wcnt` 8 bits, timeout counter 16 bits; neither wraps.

## Timing
- Reset (`rst`=0, asynchronous), all outputs:
  - state=IDLE, `req_ready`=1 after reset release
  - `rsp_valid`=0, `rsp_data`=0, `rsp_mode`=0, `rsp_err`=0
  - `aes_ld`=0, `aes_kld`=0, `aes_mode`=0, `aes_key`=0, `aes_text_in`=0
  - `kvalid`=0
- Reset mid-job aborts immediately: no response is produced and the cache is invalidated.
- Cycle numbering, with the accept at cycle 0:
  - Encrypt, or decrypt with cache hit: `aes_ld` at cycle 1; BUSY from cycle 2.
  - Decrypt miss: `aes_kld` at cycle 1; KWAIT cycles 2..1+KEY_EXP_CYCLES; `aes_ld` at cycle 2+KEY_EXP_CYCLES.
  - `aes_done` sampled high at BUSY cycle k gives `rsp_valid`=1 at k+1.
  - Timeout: `rsp_valid` at (first BUSY cycle)+TIMEOUT.
- Response handshake: `rsp_valid && rsp_ready` at cycle r gives state IDLE and `req_ready`=1 at r+1. There is no back-to-back bypass; one job is in flight at a time.
- `rsp_valid` never drops without `rsp_ready`. Response fields are stable while `rsp_valid`=1.

## Test plan
- Encrypt FIPS-197 C.1 through the AES core wrapper:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff.
  - Required: `aes_ld` at cycle 1, `aes_kld` never asserted, `rsp_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `rsp_mode`=0, `rsp_err`=0.
- Decrypt, cold cache:
  - Stimulus: same key, data 69c4e0d8…c55a.
  - Required: `aes_kld` at cycle 1, `aes_ld` at cycle 14 (KEY_EXP_CYCLES=12), `rsp_data`=00112233…eeff.
- Repeat the same decrypt:
  - Required: no `aes_kld`, `aes_ld` at cycle 1, same result.
  - Then decrypt with key 0f0e…00: `aes_kld` is reasserted.
- Stub core that never asserts done, TIMEOUT=8:
  - Required: `rsp_valid` 8 cycles after BUSY entry, `rsp_err`=1, `rsp_data`=0.
  - Next decrypt with the previous key: `aes_kld` asserted (cache invalidated).
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 20 cycles, plus a spurious `aes_done` pulse in IDLE/RESP.
  - Required: `rsp_*` stable, `req_ready`=0 throughout, spurious pulse ignored, `req_ready`=1 the cycle after the handshake.
- Reset:
  - Stimulus: assert `rst`=0 during KWAIT and during BUSY.
  - Required: all outputs at reset values asynchronously; no `rsp_valid`; next decrypt performs `aes_kld`.

Source files
------------

// File: rtl/aes_host_ctrl.sv
// -----------------------------------------------------------------------------
// aes_host_ctrl
//
// Request-side controller for an AES core wrapper. It accepts one 128-bit
// encrypt/decrypt job at a time and sequences the core strobes (kld for
// inverse-cipher key expansion, then ld). It captures the core result, or
// reports a timeout error, and returns it over a response port.
//
// The last key expanded for decryption is cached. A decrypt job that
// presents the same key again skips the kld strobe and the expansion wait.
// Encrypt jobs neither read nor touch the cache. A timeout invalidates the
// cache, because the core's expanded-key state is then unknown.
//
// Handshakes (valid/ready):
//   A transfer happens on a rising edge where valid && ready. The producer
//   holds valid and payload stable until that edge. The consumer may hold
//   ready low indefinitely. Here req_ready is high only in IDLE. rsp_valid
//   is high only in RESP, and the rsp_* fields are frozen there.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_mode             0 = encrypt, 1 = decrypt
//   req_key, req_data    cipher key and input block
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             result block (0 on error)
//   rsp_mode, rsp_err    mode of the completed job; 1 = timeout
//   aes_mode, aes_ld, aes_kld, aes_key, aes_text_in    drive the core
//   aes_text_out, aes_done                             returned by the core
//   dbg_state, dbg_kvalid                              FSM state and cache-valid flag
// -----------------------------------------------------------------------------
module aes_host_ctrl #(
    parameter int KEY_EXP_CYCLES = 12,  // 1..255
    parameter int TIMEOUT        = 64   // 1..65535
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_mode,
    input  logic [127:0] req_key,
    input  logic [127:0] req_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_mode,
    output logic         rsp_err,
    output logic         aes_mode,
    output logic         aes_ld,
    output logic         aes_kld,
    output logic [127:0] aes_key,
    output logic [127:0] aes_text_in,
    input  logic [127:0] aes_text_out,
    input  logic         aes_done,
    output logic [2:0]   dbg_state,
    output logic         dbg_kvalid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KLD   = 3'd1,
        S_KWAIT = 3'd2,
        S_LOAD  = 3'd3,
        S_BUSY  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_mode;
    logic [127:0]  r_key;
    logic [127:0]  r_text;
    logic [127:0]  r_kcache;
    logic          r_kvalid;
    logic [7:0]    r_wcnt;
    logic [15:0]   r_tcnt;
    logic [127:0]  r_rsp_data;
    logic          r_rsp_mode;
    logic          r_rsp_err;

    logic          w_hit;
    logic          w_tmo;

    assign w_hit = r_kvalid && (req_key == r_kcache);
    // The counter holds the number of BUSY cycles already spent without done.
    // The current cycle is the last one allowed when the counter equals TIMEOUT-1.
    assign w_tmo = (r_tcnt == 16'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and strobes
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        aes_ld    = 1'b0;
        aes_kld   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = (req_mode && !w_hit) ? S_KLD : S_LOAD;
                end
            end
            S_KLD: begin
                aes_kld = 1'b1;
                w_next  = S_KWAIT;
            end
            S_KWAIT: begin
                if (r_wcnt == 8'd1) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                aes_ld = 1'b1;
                w_next = S_BUSY;
            end
            S_BUSY: begin
                if (aes_done || w_tmo) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: job registers, key cache, counters, response capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode     <= 1'b0;
            r_key      <= '0;
            r_text     <= '0;
            r_kcache   <= '0;
            r_kvalid   <= 1'b0;
            r_wcnt     <= '0;
            r_tcnt     <= '0;
            r_rsp_data <= '0;
            r_rsp_mode <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_mode <= req_mode;
                        r_key  <= req_key;
                        r_text <= req_data;
                    end
                end
                S_KLD: begin
                    r_kcache <= r_key;
                    r_kvalid <= 1'b1;
                    r_wcnt   <= 8'(KEY_EXP_CYCLES);
                end
                S_KWAIT: begin
                    if (r_wcnt != 8'd1) begin
                        r_wcnt <= r_wcnt - 8'd1;
                    end
                end
                S_LOAD: begin
                    r_tcnt <= '0;
                end
                S_BUSY: begin
                    // done takes priority over a coincident timeout
                    if (aes_done) begin
                        r_rsp_data <= aes_text_out;
                        r_rsp_mode <= r_mode;
                        r_rsp_err  <= 1'b0;
                    end else if (w_tmo) begin
                        r_rsp_data <= '0;
                        r_rsp_mode <= r_mode;
                        r_rsp_err  <= 1'b1;
                        r_kvalid   <= 1'b0;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign aes_mode    = r_mode;
    assign aes_key     = r_key;
    assign aes_text_in = r_text;
    assign rsp_data    = r_rsp_data;
    assign rsp_mode    = r_rsp_mode;
    assign rsp_err     = r_rsp_err;
    assign dbg_state   = r_state;
    assign dbg_kvalid  = r_kvalid;

endmodule

// File: tb/tb_aes_host_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_host_ctrl
//
// Bench for aes_host_ctrl with KEY_EXP_CYCLES=12 and TIMEOUT=8. A stub core
// stands in for the AES wrapper:
//   - It returns the FIPS-197 C.1 pair for that key and block.
//   - For other inputs it returns a simple invertible mixing function.
//   - Decryption uses the key latched by the last kld, so a missing kld
//     produces a wrong result.
//   - After ld it raises done a programmable number of cycles later, or
//     never when the latency is 0.
// The reference model works at job level. It predicts kld/ld cycles,
// response cycle, result and cache state from the operation rules.
// -----------------------------------------------------------------------------
module tb_aes_host_ctrl;

    localparam int KEXP = 12;
    localparam int TMO  = 8;

    localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h0f0e0d0c0b0a09080706050403020100;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_mode;
    logic [127:0] req_key, req_data;
    logic         rsp_valid, rsp_ready, rsp_mode, rsp_err;
    logic [127:0] rsp_data;
    logic         aes_mode, aes_ld, aes_kld, aes_done;
    logic [127:0] aes_key, aes_text_in, aes_text_out;
    logic [2:0]   dbg_state;
    logic         dbg_kvalid;

    // stub core state
    int           stub_lat;
    logic         spur_done;
    int           st_cnt;
    logic         st_done;
    logic [127:0] st_dkey, st_res, st_out;

    // reference model state and counters
    logic         m_kvalid;
    logic [127:0] m_kcache;
    int           n_vec;
    int           n_err;

    always #5 clk = ~clk;

    aes_host_ctrl #(.KEY_EXP_CYCLES(KEXP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_key(req_key), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_mode(rsp_mode), .rsp_err(rsp_err),
        .aes_mode(aes_mode), .aes_ld(aes_ld), .aes_kld(aes_kld),
        .aes_key(aes_key), .aes_text_in(aes_text_in),
        .aes_text_out(aes_text_out), .aes_done(aes_done),
        .dbg_state(dbg_state), .dbg_kvalid(dbg_kvalid)
    );

    function automatic logic [127:0] swap64(input logic [127:0] x);
        return {x[63:0], x[127:64]};
    endfunction

    // Core behaviour: known FIPS pair, otherwise a keyed invertible mix
    function automatic logic [127:0] cipher(input logic m, input logic [127:0] k,
                                            input logic [127:0] d);
        if (!m && k == FK && d == FP) return FC;
        if (m && k == FK && d == FC) return FP;
        return m ? swap64(d ^ k) : (swap64(d) ^ k);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_cnt  <= 0;
            st_done <= 1'b0;
            st_dkey <= '0;
            st_res  <= '0;
            st_out  <= '0;
        end else begin
            st_done <= 1'b0;
            if (aes_kld) st_dkey <= aes_key;
            if (st_cnt != 0) begin
                st_cnt <= st_cnt - 1;
                if (st_cnt == 1) begin
                    st_done <= 1'b1;
                    st_out  <= st_res;
                end
            end else if (aes_ld && stub_lat != 0) begin
                st_cnt <= stub_lat;
                st_res <= cipher(aes_mode, aes_mode ? st_dkey : aes_key, aes_text_in);
            end
        end
    end

    assign aes_done     = st_done | spur_done;
    assign aes_text_out = st_out;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete job: accept, observe strobes, check the response,
    // optionally stall it for `hold` cycles, then hand it off.
    task automatic run_job(input logic m, input logic [127:0] k, input logic [127:0] d,
                           input int lat, input int hold, input bit spur);
        bit           exp_kld, exp_err;
        int           exp_ld, exp_rsp, b;
        logic [127:0] exp_data;
        int           kld_cyc, ld_cyc, rsp_cyc, n_kld, n_ld, cyc;
        logic [2:0]   st_snap;

        exp_kld = m && !(m_kvalid && k == m_kcache);
        if (exp_kld) begin
            m_kvalid = 1'b1;
            m_kcache = k;
        end
        exp_ld   = exp_kld ? 2 + KEXP : 1;
        b        = exp_ld + 1;
        exp_err  = (lat == 0) || (lat >= TMO);
        exp_rsp  = exp_err ? b + TMO : b + lat + 1;
        exp_data = exp_err ? '0 : cipher(m, k, d);
        if (exp_err) m_kvalid = 1'b0;

        stub_lat = lat;
        chk("idle_req_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_mode  = m;
        req_key   = k;
        req_data  = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_key   = {$urandom, $urandom, $urandom, $urandom};
        req_data  = {$urandom, $urandom, $urandom, $urandom};
        req_mode  = ~m;

        kld_cyc = -1; ld_cyc = -1; rsp_cyc = -1; n_kld = 0; n_ld = 0;
        for (cyc = 1; cyc < 200; cyc++) begin
            if (aes_kld) begin n_kld++; kld_cyc = cyc; end
            if (aes_ld) begin
                n_ld++;
                ld_cyc = cyc;
                chk("ld_key", aes_key, k);
                chk("ld_text", aes_text_in, d);
                chk("ld_mode", aes_mode, m);
            end
            if (rsp_valid) begin
                rsp_cyc = cyc;
                break;
            end
            @(negedge clk);
        end

        chk("kld_count", n_kld, exp_kld ? 1 : 0);
        if (exp_kld) chk("kld_cycle", kld_cyc, 1);
        chk("ld_count", n_ld, 1);
        chk("ld_cycle", ld_cyc, exp_ld);
        chk("rsp_cycle", rsp_cyc, exp_rsp);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_mode", rsp_mode, m);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_req_ready", req_ready, 1'b0);

        st_snap = dbg_state;
        for (int i = 0; i < hold; i++) begin
            if (spur && i == 0) spur_done = 1'b1;
            @(negedge clk);
            spur_done = 1'b0;
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_req_ready", req_ready, 1'b0);
            chk("hold_data", rsp_data, exp_data);
            chk("hold_err", rsp_err, exp_err);
            chk("hold_mode", rsp_mode, m);
            chk("hold_state", dbg_state, st_snap);
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_req_ready", req_ready, 1'b1);
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("cache_valid", dbg_kvalid, m_kvalid);

        if (spur) begin
            spur_done = 1'b1;
            @(negedge clk);
            spur_done = 1'b0;
            chk("idle_spur_ready", req_ready, 1'b1);
            chk("idle_spur_valid", rsp_valid, 1'b0);
        end
    endtask

    // Start a job, let it run n cycles past the accept, then reset mid-cycle.
    task automatic reset_mid(input logic m, input logic [127:0] k, input logic [127:0] d,
                             input int n);
        stub_lat  = 0;
        chk("rst_idle_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_mode  = m;
        req_key   = k;
        req_data  = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        chk("arst_aes_ld", aes_ld, 1'b0);
        chk("arst_aes_kld", aes_kld, 1'b0);
        chk("arst_aes_mode", aes_mode, 1'b0);
        chk("arst_aes_key", aes_key, '0);
        chk("arst_aes_text", aes_text_in, '0);
        chk("arst_rsp_data", rsp_data, '0);
        chk("arst_rsp_mode", rsp_mode, 1'b0);
        chk("arst_rsp_err", rsp_err, 1'b0);
        chk("arst_kvalid", dbg_kvalid, 1'b0);
        m_kvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_valid", rsp_valid, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rel_ready", req_ready, 1'b1);
        chk("rst_rel_valid", rsp_valid, 1'b0);
    endtask

    logic [127:0] pool [3];

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_kvalid  = 1'b0;
        m_kcache  = '0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_mode  = 1'b0;
        req_key   = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        spur_done = 1'b0;
        stub_lat  = 0;

        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_data", rsp_data, '0);
        chk("reset_rsp_err", rsp_err, 1'b0);
        chk("reset_aes_key", aes_key, '0);
        chk("reset_aes_ld", aes_ld, 1'b0);
        chk("reset_aes_kld", aes_kld, 1'b0);
        chk("reset_kvalid", dbg_kvalid, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1'b1);

        // FIPS-197 C.1 encrypt, cold and warm decrypt, key change
        run_job(1'b0, FK, FP, 3, 0, 1'b0);
        run_job(1'b1, FK, FC, 4, 0, 1'b0);
        run_job(1'b1, FK, FC, 2, 0, 1'b0);
        run_job(1'b1, K2, FC, 5, 1, 1'b0);
        // Timeout on a cache hit invalidates the cache
        run_job(1'b1, K2, FC, 0, 0, 1'b0);
        run_job(1'b1, K2, FC, 3, 0, 1'b0);
        // done coincident with the last BUSY cycle wins; one cycle later loses
        run_job(1'b0, FK, FP, TMO - 1, 0, 1'b0);
        run_job(1'b0, FK, FP, TMO, 2, 1'b0);
        // Backpressure with spurious done pulses in RESP and IDLE
        run_job(1'b0, FK, FP, 2, 20, 1'b1);
        // Reset during KWAIT, then during BUSY of a cache hit
        reset_mid(1'b1, FK, FC, 4);
        run_job(1'b1, FK, FC, 2, 0, 1'b0);
        reset_mid(1'b1, FK, FC, 3);
        run_job(1'b1, FK, FC, 3, 0, 1'b0);

        // Randomized jobs over a small key pool so hits and misses both occur
        for (int i = 0; i < 3; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int j = 0; j < 24; j++) begin
            run_job(1'($urandom_range(0, 1)),
                    pool[$urandom_range(0, 2)],
                    {$urandom, $urandom, $urandom, $urandom},
                    int'($urandom_range(0, TMO)),
                    int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
